// File: rtl/rt_pkg.sv
// Shared types and constants for the reaction-time tester core.
package rt_pkg;

  // Width of the measured reaction time and of the random word.
  localparam int unsigned RT_W   = 14;
  localparam int unsigned RAND_W = 16;

  // Board defaults (100 MHz clock).
  localparam int unsigned DEF_TICK_DIV     = 100000;
  localparam int unsigned DEF_MIN_DELAY_MS = 1000;
  localparam int unsigned DEF_RAND_BITS    = 11;
  localparam int unsigned DEF_MAX_RT_MS    = 9999;

  typedef enum logic [2:0] {
    StIdle,
    StArm0,
    StArm1,
    StWait,
    StGo,
    StDone
  } rt_state_e;

  // True for every state in which a trial is in progress.
  function automatic logic state_is_busy(rt_state_e s);
    return !((s == StIdle) || (s == StDone));
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..TICK_DIV-1 and flags the last count as tick.
// clr restarts the count at 0 so the following millisecond is a full one.
module ms_tick_gen #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running prescaler with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/reaction_timer_core.sv
// Reaction-time tester core: draws a random foreperiod, lights the stimulus,
// then measures the time to the next button press in milliseconds.
// Optional macro FALSE_START_DETECT_EN: a press before the stimulus ends the
// trial with the early flag set.
// The random input is named rand_word because rand is a reserved word.
module reaction_timer_core
  import rt_pkg::*;
#(
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned MIN_DELAY_MS = DEF_MIN_DELAY_MS,
  parameter int unsigned RAND_BITS    = DEF_RAND_BITS,
  parameter int unsigned MAX_RT_MS    = DEF_MAX_RT_MS
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              btn,
  input  logic [RAND_W-1:0] rand_word,
  output logic              reload,
  output logic              stim,
  output logic              busy,
  output logic [RT_W-1:0]   rt_ms,
  output logic              rt_valid,
  output logic              timeout,
  output logic              early
);

  localparam logic [RAND_W-1:0] MIN_DELAY = RAND_W'(MIN_DELAY_MS);
  localparam logic [RAND_W-1:0] RAND_MASK = RAND_W'((64'd1 << RAND_BITS) - 64'd1);
  localparam logic [RT_W-1:0]   RT_LIMIT  = RT_W'(MAX_RT_MS);
  localparam logic [RT_W-1:0]   RT_LAST   = RT_W'(MAX_RT_MS - 1);

  rt_state_e         state;
  logic              btn_q;
  logic              press;
  logic              tick;
  logic              tick_clr;
  logic              wait_done;
  logic              false_start;
  logic [RAND_W-1:0] delay_ms;
  logic [RT_W-1:0]   rt_cnt;

  // Button edge detector: only a fresh rising edge counts as a press.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn;
    end
  end

  assign press = btn & ~btn_q;

  // Last millisecond of the foreperiod has just elapsed.
  assign wait_done = (state == StWait) && tick && (delay_ms < RAND_W'(2));

  // Restart the prescaler on entry to WAIT and to GO.
  assign tick_clr = (state == StArm1) || wait_done;

`ifdef FALSE_START_DETECT_EN
  assign false_start = press && (state inside {StArm0, StArm1, StWait});
`else
  assign false_start = 1'b0;
`endif

  ms_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_ms_tick_gen (
    .clk  (clk),
    .rstn (rstn),
    .clr  (tick_clr),
    .tick (tick)
  );

  // Trial FSM with registered outputs and the foreperiod / reaction counters.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= StIdle;
      reload   <= 1'b0;
      stim     <= 1'b0;
      busy     <= 1'b0;
      rt_ms    <= '0;
      rt_valid <= 1'b0;
      timeout  <= 1'b0;
      early    <= 1'b0;
      delay_ms <= '0;
      rt_cnt   <= '0;
    end else begin
      reload   <= 1'b0;
      rt_valid <= 1'b0;
      if (false_start) begin
        state    <= StDone;
        stim     <= 1'b0;
        busy     <= 1'b0;
        rt_ms    <= '0;
        rt_valid <= 1'b1;
        timeout  <= 1'b0;
        early    <= 1'b1;
      end else begin
        case (state)
          StIdle, StDone: begin
            if (start) begin
              state  <= StArm0;
              reload <= 1'b1;
              busy   <= 1'b1;
              stim   <= 1'b0;
            end
          end
          StArm0: begin
            state <= StArm1;
          end
          StArm1: begin
            // The generator has advanced in ARM0, so rand_word is fresh here.
            delay_ms <= MIN_DELAY + (rand_word & RAND_MASK);
            timeout  <= 1'b0;
            early    <= 1'b0;
            state    <= StWait;
          end
          StWait: begin
            if (wait_done) begin
              state  <= StGo;
              stim   <= 1'b1;
              rt_cnt <= '0;
            end else if (tick) begin
              delay_ms <= delay_ms - RAND_W'(1);
            end
          end
          StGo: begin
            // A press beats a simultaneous limiting tick.
            if (press) begin
              rt_ms    <= rt_cnt;
              rt_valid <= 1'b1;
              stim     <= 1'b0;
              busy     <= 1'b0;
              state    <= StDone;
            end else if (tick) begin
              if (rt_cnt == RT_LAST) begin
                rt_ms    <= RT_LIMIT;
                timeout  <= 1'b1;
                rt_valid <= 1'b1;
                stim     <= 1'b0;
                busy     <= 1'b0;
                state    <= StDone;
              end else begin
                rt_cnt <= rt_cnt + RT_W'(1);
              end
            end
          end
          default: begin
            state <= StIdle;
            busy  <= state_is_busy(StIdle);
            stim  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reaction_timer_core.sv
// Self-checking bench for reaction_timer_core (TICK_DIV=10, MIN_DELAY_MS=5,
// RAND_BITS=3, MAX_RT_MS=20). Expected results are queued when stimulus is
// driven and compared when rt_valid pulses.
module tb_reaction_timer_core;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        btn = 1'b0;
  logic [15:0] rand_word = 16'h0000;
  logic        reload;
  logic        stim;
  logic        busy;
  logic [13:0] rt_ms;
  logic        rt_valid;
  logic        timeout;
  logic        early;

  reaction_timer_core #(
    .TICK_DIV     (10),
    .MIN_DELAY_MS (5),
    .RAND_BITS    (3),
    .MAX_RT_MS    (20)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .btn       (btn),
    .rand_word (rand_word),
    .reload    (reload),
    .stim      (stim),
    .busy      (busy),
    .rt_ms     (rt_ms),
    .rt_valid  (rt_valid),
    .timeout   (timeout),
    .early     (early)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [13:0] rt;
    logic        to;
    logic        er;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int reload_hi = 0;
  int valid_cnt = 0;
  int stim_rises = 0;
  logic stim_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int rt, input bit to, input bit er);
    exp_t e;
    e.rt = 14'(rt);
    e.to = to;
    e.er = er;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor and scoreboard consumer.
  always @(negedge clk) begin
    if (reload === 1'b1) reload_hi <= reload_hi + 1;
    if (stim === 1'b1 && stim_prev !== 1'b1) stim_rises <= stim_rises + 1;
    stim_prev <= stim;
    if (rt_valid === 1'b1) begin
      valid_cnt <= valid_cnt + 1;
      if (exp_q.size() == 0) begin
        check("unexpected_rt_valid", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rt_ms", 32'(rt_ms), 32'(mon_e.rt));
        check("timeout", 32'(timeout), 32'(mon_e.to));
        check("early", 32'(early), 32'(mon_e.er));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  task automatic wait_stim(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (stim === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("stim_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (rt_valid === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("rt_valid_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic check_near(input string tag, input int got, input int exp);
    check($sformatf("%s_%0d", tag, got), 32'((got >= exp - 1) && (got <= exp + 1)), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c1, at, vat, r0, v0, s0;

    // Reset and idle.
    rstn = 1'b0;
    cycles(3);
    @(negedge clk);
    check("rst_reload", 32'(reload), 32'd0);
    check("rst_stim", 32'(stim), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rt_ms", 32'(rt_ms), 32'd0);
    check("rst_rt_valid", 32'(rt_valid), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_early", 32'(early), 32'd0);
    cycles(1);
    rstn = 1'b1;
    r0 = reload_hi;
    cycles(100);
    check("idle_reload", 32'(reload_hi - r0), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Trial A: delay 8 ms, press 37 cycles into GO -> 3 ms.
    rand_word = 16'hFFF3;
    r0 = reload_hi;
    v0 = valid_cnt;
    pulse_start();
    c1 = cyc;
    wait_stim(200, at);
    check_near("a_stim_delay", at - (c1 + 2), 80);
    cycles(37);
    push_exp(3, 1'b0, 1'b0);
    btn = 1'b1;
    wait_valid(100, vat);
    cycles(2);
    btn = 1'b0;
    check("a_reload_once", 32'(reload_hi - r0), 32'd1);
    check("a_valid_once", 32'(valid_cnt - v0), 32'd1);
    check("a_stim_off", 32'(stim), 32'd0);
    check("a_busy_off", 32'(busy), 32'd0);

    // Trial B: delay 5 ms, no press -> timeout at 20 ms.
    rand_word = 16'h0000;
    v0 = valid_cnt;
    pulse_start();
    c1 = cyc;
    push_exp(20, 1'b1, 1'b0);
    wait_stim(200, at);
    check_near("b_stim_delay", at - (c1 + 2), 50);
    wait_valid(300, vat);
    check_near("b_timeout_delay", vat - at, 200);
    cycles(2);
    check("b_valid_once", 32'(valid_cnt - v0), 32'd1);
    check("b_timeout_sticky", 32'(timeout), 32'd1);
    check("b_rt_ms_limit", 32'(rt_ms), 32'd20);
    check("b_stim_off", 32'(stim), 32'd0);

    // Trial C: press during WAIT.
    rand_word = 16'h0000;
    s0 = stim_rises;
    pulse_start();
    c1 = cyc;
    cycles(21);
`ifdef FALSE_START_DETECT_EN
    push_exp(0, 1'b0, 1'b1);
    btn = 1'b1;
    cycles(3);
    btn = 1'b0;
    wait_valid(50, vat);
    cycles(60);
    check("c_stim_never", 32'(stim_rises - s0), 32'd0);
    check("c_early_set", 32'(early), 32'd1);
    check("c_rt_ms_zero", 32'(rt_ms), 32'd0);
    check("c_timeout_clr", 32'(timeout), 32'd0);
`else
    btn = 1'b1;
    cycles(3);
    btn = 1'b0;
    wait_stim(100, at);
    check_near("c_stim_delay", at - (c1 + 2), 50);
    cycles(25);
    push_exp(2, 1'b0, 1'b0);
    btn = 1'b1;
    wait_valid(100, vat);
    cycles(2);
    btn = 1'b0;
    check("c_stim_lit", 32'(stim_rises - s0), 32'd1);
    check("c_early_zero", 32'(early), 32'd0);
    check("c_timeout_clr", 32'(timeout), 32'd0);
`endif

    // Trial D: button held from DONE through GO needs a fresh edge.
    btn = 1'b1;
    cycles(5);
    rand_word = 16'h0000;
    pulse_start();
    wait_stim(200, at);
    v0 = valid_cnt;
    cycles(50);
    btn = 1'b0;
    check("d_held_no_react", 32'(valid_cnt - v0), 32'd0);
    check("d_still_busy", 32'(busy), 32'd1);
    cycles(5);
    push_exp(5, 1'b0, 1'b0);
    btn = 1'b1;
    wait_valid(100, vat);
    cycles(2);
    btn = 1'b0;
    check("d_valid_once", 32'(valid_cnt - v0), 32'd1);

    // Trial E: reset mid-GO, then a clean trial with a start during WAIT.
    rand_word = 16'h0000;
    pulse_start();
    wait_stim(200, at);
    cycles(20);
    v0 = valid_cnt;
    rstn = 1'b0;
    cycles(1);
    rstn = 1'b1;
    @(negedge clk);
    check("e_rst_stim", 32'(stim), 32'd0);
    check("e_rst_busy", 32'(busy), 32'd0);
    check("e_rst_rt_ms", 32'(rt_ms), 32'd0);
    check("e_rst_flags", 32'({timeout, early, rt_valid, reload}), 32'd0);
    cycles(30);
    check("e_no_valid_after_rst", 32'(valid_cnt - v0), 32'd0);
    check("e_idle_busy", 32'(busy), 32'd0);
    rand_word = 16'h0002;
    r0 = reload_hi;
    pulse_start();
    c1 = cyc;
    cycles(10);
    pulse_start();
    wait_stim(200, at);
    check_near("e_stim_delay", at - (c1 + 2), 70);
    cycles(15);
    push_exp(1, 1'b0, 1'b0);
    btn = 1'b1;
    wait_valid(100, vat);
    cycles(2);
    btn = 1'b0;
    check("e_reload_once", 32'(reload_hi - r0), 32'd1);

    cycles(5);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reaction_timer_core.md
Name: reaction_timer_core

Overview:
- Consumes the 16-bit pseudo-random word from the random generator and drives its reload request.
- On a start request it draws a random foreperiod, waits that long, lights the stimulus, then measures the player's reaction time in milliseconds.
- Sits between the random generator, the debounced push-buttons and the display/score logic of the reaction-time tester.

Parameters:
- TICK_DIV, 100000, clock cycles per 1 ms tick (100 MHz board); benches use 10.
- MIN_DELAY_MS, 1000, minimum foreperiod in ms.
- RAND_BITS, 11, low rand bits added to MIN_DELAY_MS; extra foreperiod range 0..2047 ms.
- MAX_RT_MS, 9999, reaction-time ceiling; reaching it is a timeout.

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- start  in  1  one-cycle start request (debounced)
- btn  in  1  reaction button level (debounced, active-high)
- rand  in  16  random word from the generator
- reload  out  1  one-cycle request to the generator to advance/reload
- stim  out  1  stimulus LED, high while waiting for the reaction
- busy  out  1  high in every state except IDLE and DONE
- rt_ms  out  14  measured reaction time in ms
- rt_valid  out  1  one-cycle pulse when rt_ms is updated
- timeout  out  1  sticky flag: no press before MAX_RT_MS
- early  out  1  sticky flag: false start (optional feature)

Behaviour:
- Reset (rstn=0 at a clk edge) puts the block in IDLE.
  - Reset values: reload=0, stim=0, busy=0, rt_ms=0, rt_valid=0, timeout=0, early=0.
  - The ms prescaler and all counters clear.
  - Reset mid-run aborts immediately; no rt_valid is emitted.
- ms tick: the prescaler counts 0..TICK_DIV-1 and pulses tick for one cycle at TICK_DIV-1.
  - The prescaler restarts at 0 on every entry to WAIT and to GO, so the first ms is always a full ms.
- Button edge: btn is registered once; press = btn & ~btn_q. Only rising edges count.
- States:
  - IDLE: on start → ARM0. Other inputs are ignored.
  - ARM0: reload=1 for this single cycle → ARM1.
  - ARM1: reload=0. At the end of the cycle, latch delay_ms = MIN_DELAY_MS + rand[RAND_BITS-1:0] (zero-extended, 16-bit sum, no overflow at defaults). Clear timeout, early and the prescaler → WAIT.
  - WAIT: delay_ms decrements on each tick. When a tick arrives with delay_ms==1 → GO.
  - GO: stim=1. rt_cnt starts at 0 and increments on each tick.
    - On press: rt_ms←rt_cnt, rt_valid pulses on the next cycle → DONE.
    - If a tick would take rt_cnt to MAX_RT_MS: rt_ms←MAX_RT_MS, timeout←1, rt_valid pulses → DONE.
    - Press and the limiting tick in the same cycle: the press wins; rt_ms is the pre-tick rt_cnt.
  - DONE: stim=0. Holds rt_ms and the flags. On start → ARM0, which starts a new trial without an intermediate IDLE.
- start while busy is ignored.
- rt_ms resolution is 1 ms, truncated; a press within the first ms gives rt_ms=0.
- Total foreperiod = delay_ms ms ±1 cycle, measured from the ARM1 edge.

Optional Feature:
- Macro: FALSE_START_DETECT_EN
- Defined:
  - A press in WAIT → DONE with early=1, rt_ms=0, rt_valid pulsed, stim never lit.
  - A press in ARM0/ARM1 is treated the same way.
- Undefined:
  - Presses in ARM/WAIT are ignored; early is tied to 0.
  - A button already held when GO is entered does not count; a fresh rising edge is required.

Decomposition:
- Package rt_pkg:
  - State enum (IDLE, ARM0, ARM1, WAIT, GO, DONE).
  - Width constants: RT_W=14, RAND_W=16.
  - Default timing constants.
- One sub-module, ms_tick_gen: prescaler with clk, rstn, clr and tick, parameterised by TICK_DIV.
- FSM, counters and edge detect stay in reaction_timer_core.

Test Plan (TICK_DIV=10, MIN_DELAY_MS=5, RAND_BITS=3, MAX_RT_MS=20):
- Reset then idle: all outputs 0; reload stays 0 with start=0 for 100 cycles.
- start pulse, rand=16'hFFF3 → reload high exactly 1 cycle; delay_ms=8; stim rises 80±1 cycles after ARM1. Press 37 cycles after stim rises → rt_ms=3, rt_valid pulses once, stim drops.
- rand=16'h0000, no press → stim after 50 cycles; timeout=1 and rt_ms=20 after 200 cycles; one rt_valid.
- With FALSE_START_DETECT_EN defined, press 20 cycles into WAIT → early=1, rt_ms=0, stim never high. With the macro undefined, the same stimulus is ignored and the trial completes normally.
- btn held high since IDLE through GO → no reaction; a release then press 55 cycles into GO → rt_ms=5.
- rstn low for one cycle mid-GO → all outputs 0, IDLE; a following start runs a clean trial. A start pulse during WAIT is ignored (single reload per trial).
